booth_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that lets up to eight requesters share one 16x16 signed Booth multiplier (`booth_m`, combinational, 32-bit product). It registers the granted operands, runs them through the multiplier for one cycle, and holds the registered product with the requester ID until the consumer accepts it. One operation is in flight at a time. The block sits between requester-side valid/ready channels and a single result channel.

---
 rtl/booth_mult_arbiter_if.sv | 24 ++
 rtl/booth_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_arbiter_if.sv
// Requester and result channels of the shared Booth multiplier arbiter.
// The master side drives requests and accepts results; the slave side is the arbiter.
interface booth_mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_x;
  logic [16*NREQ-1:0]   req_y;
  logic                 res_valid;
  logic                 res_ready;
  logic [2:0]           res_id;
  logic [31:0]          res_product;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_id, res_product
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_id, res_product
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that time-shares one combinational radix-4 Booth 16x16 signed
// multiplier between up to eight requesters, one operation in flight at a time.

module booth_m (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);
  logic [16:0]        y_ext;
  logic signed [31:0] x_ext;
  logic signed [31:0] pp;
  logic signed [31:0] acc;
  logic [2:0]         sel;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    y_ext = {y, 1'b0};
    x_ext = 32'(signed'(x));
    acc   = '0;
    pp    = '0;
    sel   = '0;
    // Each overlapping triplet {y[2i+1], y[2i], y[2i-1]} selects 0, +-x or +-2x.
    for (int i = 0; i < 8; i++) begin
      sel = y_ext[2*i +: 3];
      case (sel)
        3'b001, 3'b010: pp = x_ext;
        3'b011:         pp = x_ext <<< 1;
        3'b100:         pp = -(x_ext <<< 1);
        3'b101, 3'b110: pp = -x_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
    p = acc;
  end
endmodule

module booth_mult_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_mult_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [2:0]          ptr;
  logic [2:0]          id_q;
  logic [15:0]         x_q;
  logic [15:0]         y_q;
  logic [31:0]         prod_q;
  logic [31:0]         prod_c;

  logic [2*NREQ-1:0]   dbl_valid;
  logic [NREQ-1:0]     rot_valid;
  logic [3:0]          sum;
  logic [2:0]          gnt;
  logic                gnt_found;
  logic [15:0]         sel_x;
  logic [15:0]         sel_y;

  // Rotating the doubled request vector by ptr puts the highest-priority requester at bit 0;
  // scanning downward lets the lowest rotated position win.
  always_comb begin
    dbl_valid = {bus.req_valid, bus.req_valid};
    rot_valid = NREQ'(dbl_valid >> ptr);
    gnt       = '0;
    gnt_found = 1'b0;
    sum       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        sum       = {1'b0, ptr} + 4'(k);
        gnt       = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_x         = '0;
    sel_y         = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == 3'(i)) begin
        sel_x = bus.req_x[16*i +: 16];
        sel_y = bus.req_y[16*i +: 16];
      end
      bus.req_ready[i] = (state == IDLE) && gnt_found && (gnt == 3'(i));
    end
  end

  booth_m u_booth (
    .x (x_q),
    .y (y_q),
    .p (prod_c)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      id_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A valid granted request is always accepted, so gnt_found is the handshake.
          if (gnt_found) begin
            x_q   <= sel_x;
            y_q   <= sel_y;
            id_q  <= gnt;
            state <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod_c;
          state  <= DONE;
        end
        DONE: begin
          // Pointer moves only on result handshake: the served requester drops to lowest priority.
          if (bus.res_ready) begin
            ptr   <= (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid   = (state == DONE);
  assign bus.res_id      = id_q;
  assign bus.res_product = prod_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter: a negedge monitor models grant, latency and product,
// and scenario tasks drive stimulus and check spec-fixed constants.
module tb_booth_mult_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  booth_mult_arbiter_if #(.NREQ(NREQ)) bus ();

  booth_mult_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] prod;
  } res_t;

  res_t        sb[$];
  logic [2:0]  gnt_log[$];
  int          passed = 0;
  int          total  = 0;
  int          phase  = 0;
  logic [2:0]  mptr   = '0;
  int          acc_cnt = 0;
  int          res_cnt = 0;
  logic [2:0]  last_id;
  logic [31:0] last_prod;

  // Monitor state
  logic [NREQ-1:0]    exp_rdy;
  int                 mg;
  int                 midx;
  int                 dut_g;
  bit                 mfound;
  logic signed [31:0] mprod;
  res_t               entry;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
      mptr  = '0;
      sb.delete();
      total += 3;
      if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid);
      else passed++;
      if (bus.res_id !== 3'd0) $display("FAIL reset_res_id: got %0d expected 0", bus.res_id);
      else passed++;
      if (bus.res_product !== 32'd0) $display("FAIL reset_res_product: got %h expected 0", bus.res_product);
      else passed++;
    end

    mfound = 1'b0;
    mg     = 0;
    if (phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        midx = (int'(mptr) + k) % NREQ;
        if (!mfound && bus.req_valid[midx]) begin
          mfound = 1'b1;
          mg     = midx;
        end
      end
    end
    exp_rdy = '0;
    if (mfound) exp_rdy[mg] = 1'b1;

    total++;
    if (bus.req_ready !== exp_rdy) $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_rdy);
    else passed++;
    total++;
    if (bus.res_valid !== 1'(phase == 2)) $display("FAIL res_valid: got %b expected %b", bus.res_valid, phase == 2);
    else passed++;

    if (rst_n) begin
      case (phase)
        0: if (mfound) begin
          mprod = $signed(bus.req_x[16*mg +: 16]) * $signed(bus.req_y[16*mg +: 16]);
          entry.id   = 3'(mg);
          entry.prod = mprod;
          sb.push_back(entry);
          dut_g = 7;
          for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_g = i;
          gnt_log.push_back(3'(dut_g));
          acc_cnt++;
          phase = 1;
        end
        1: phase = 2;
        2: begin
          total++;
          if (sb.size() == 0) begin
            $display("FAIL result_unexpected: got id %0d product %h expected none", bus.res_id, bus.res_product);
          end else begin
            passed++;
            total += 2;
            if (bus.res_id !== sb[0].id) $display("FAIL res_id: got %0d expected %0d", bus.res_id, sb[0].id);
            else passed++;
            if (bus.res_product !== sb[0].prod) $display("FAIL res_product: got %h expected %h", bus.res_product, sb[0].prod);
            else passed++;
            if (bus.res_ready) begin
              last_id   = bus.res_id;
              last_prod = bus.res_product;
              mptr      = 3'((int'(sb[0].id) + 1) % NREQ);
              void'(sb.pop_front());
              res_cnt++;
              phase = 0;
            end
          end
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (acc_cnt < target) $display("FAIL accept_timeout: got %0d accepts expected %0d", acc_cnt, target);
    else passed++;
    #1;
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (res_cnt < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (res_cnt < target) $display("FAIL result_timeout: got %0d results expected %0d", res_cnt, target);
    else passed++;
    #1;
  endtask

  task automatic send(input int i, input logic [15:0] x, input logic [15:0] y);
    int tgt = acc_cnt + 1;
    bus.req_x[16*i +: 16] = x;
    bus.req_y[16*i +: 16] = y;
    bus.req_valid[i]      = 1'b1;
    wait_acc(tgt);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    total += 2;
    if (bus.res_valid !== 1'b0 || bus.res_product !== 32'd0) $display("FAIL reset_outputs: got %b/%h expected 0/0", bus.res_valid, bus.res_product);
    else passed++;
    if (bus.req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int r0 = res_cnt;
    bus.res_ready = 1'b1;
    send(0, 16'h8E9F, 16'hCC7C);
    wait_res(r0 + 1);
    total += 2;
    if (last_prod !== 32'h16D0C904) $display("FAIL single_product: got %h expected 16d0c904", last_prod);
    else passed++;
    if (last_id !== 3'd0) $display("FAIL single_id: got %0d expected 0", last_id);
    else passed++;
  endtask

  task automatic test_corner();
    logic [15:0] cx[4]  = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic [15:0] cy[4]  = '{16'h8000, 16'h8000, 16'h0001, 16'h1234};
    logic [31:0] ce[4]  = '{32'h40000000, 32'hC0008000, 32'hFFFFFFFF, 32'h00000000};
    int          rq[4]  = '{1, 2, 3, 3};
    for (int k = 0; k < 4; k++) begin
      int r0 = res_cnt;
      send(rq[k], cx[k], cy[k]);
      wait_res(r0 + 1);
      total++;
      if (last_prod !== ce[k]) $display("FAIL corner_%0d: got %h expected %h", k, last_prod, ce[k]);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    int a0 = acc_cnt;
    int r0 = res_cnt;
    gnt_log.delete();
    bus.res_ready = 1'b1;
    bus.req_x = {16'h8001, 16'h7FFF, 16'hF00D, 16'h0123};
    bus.req_y = {16'h0003, 16'hFFFF, 16'h1357, 16'hABCD};
    bus.req_valid = '1;
    wait_acc(a0 + 6);
    bus.req_valid = '0;
    wait_res(r0 + 6);
    total++;
    if (gnt_log.size() != 6) $display("FAIL rr_count: got %0d grants expected 6", gnt_log.size());
    else begin
      passed++;
      for (int k = 0; k < 6; k++) begin
        total++;
        if (gnt_log[k] !== exp_g[k]) $display("FAIL rr_grant_%0d: got %0d expected %0d", k, gnt_log[k], exp_g[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int r0;
    bus.res_ready = 1'b0;
    send(2, 16'h1234, 16'hFFFE);
    while (!bus.res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 3'd2 || bus.res_product !== 32'hFFFFDB98 || bus.req_ready !== '0)
        $display("FAIL bp_hold_%0d: got v=%b id=%0d p=%h rdy=%b expected v=1 id=2 p=ffffdb98 rdy=0",
                 k, bus.res_valid, bus.res_id, bus.res_product, bus.req_ready);
      else passed++;
    end
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    r0 = res_cnt;
    bus.res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (res_cnt !== r0 + 1) $display("FAIL bp_deliver: got %0d results expected %0d", res_cnt - r0, 1);
    else passed++;
  endtask

  task automatic test_pointer_skip();
    int r0 = res_cnt;
    int a0;
    bus.res_ready = 1'b1;
    send(1, 16'h0042, 16'h0010);
    wait_res(r0 + 1);
    gnt_log.delete();
    a0 = acc_cnt;
    bus.req_x[15:0]  = 16'hFFF0;  bus.req_y[15:0]  = 16'h0101;
    bus.req_x[63:48] = 16'h2222;  bus.req_y[63:48] = 16'h9999;
    bus.req_valid = 4'b1001;
    wait_acc(a0 + 2);
    bus.req_valid = '0;
    wait_res(r0 + 3);
    total += 2;
    if (gnt_log.size() < 1 || gnt_log[0] !== 3'd3) $display("FAIL skip_first: got %0d expected 3", gnt_log.size() > 0 ? gnt_log[0] : 3'd7);
    else passed++;
    if (gnt_log.size() < 2 || gnt_log[1] !== 3'd0) $display("FAIL skip_second: got %0d expected 0", gnt_log.size() > 1 ? gnt_log[1] : 3'd7);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int r0;
    int a0;
    bus.res_ready = 1'b1;
    send(2, 16'h1111, 16'h2222);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.res_id !== 3'd0 || bus.res_product !== 32'd0)
      $display("FAIL midreset_outputs: got v=%b id=%0d p=%h expected 0/0/0", bus.res_valid, bus.res_id, bus.res_product);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    r0 = res_cnt;
    a0 = acc_cnt;
    gnt_log.delete();
    bus.req_x[15:0]  = 16'h0007;  bus.req_y[15:0]  = 16'hFFF9;
    bus.req_x[63:48] = 16'h0300;  bus.req_y[63:48] = 16'h0005;
    bus.req_valid = 4'b1001;
    rst_n = 1'b1;
    wait_acc(a0 + 1);
    bus.req_valid = '0;
    wait_res(r0 + 1);
    repeat (4) @(posedge clk);
    #1;
    total += 3;
    if (gnt_log.size() < 1 || gnt_log[0] !== 3'd0) $display("FAIL midreset_grant: got %0d expected 0", gnt_log.size() > 0 ? gnt_log[0] : 3'd7);
    else passed++;
    if (last_id !== 3'd0 || last_prod !== 32'hFFFFFFCF) $display("FAIL midreset_result: got id=%0d p=%h expected id=0 p=ffffffcf", last_id, last_prod);
    else passed++;
    if (res_cnt !== r0 + 1) $display("FAIL midreset_count: got %0d results expected 1", res_cnt - r0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end
endmodule
